// File: rtl/sonido_pkg.sv
// Shared note table, state encoding and duty codes for the tone sequencer.
// Half-period constants are derived at elaboration time only.
package sonido_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [1:0] DUTY_50 = 2'b00;
    localparam logic [1:0] DUTY_25 = 2'b01;
    localparam logic [1:0] DUTY_12 = 2'b10;
    localparam logic [1:0] DUTY_75 = 2'b11;

    function automatic int note_hz(input int code);
        int f;
        case (code)
            1:       f = 262;
            2:       f = 277;
            3:       f = 294;
            4:       f = 311;
            5:       f = 330;
            6:       f = 349;
            7:       f = 370;
            8:       f = 392;
            9:       f = 415;
            10:      f = 440;
            11:      f = 466;
            12:      f = 494;
            13:      f = 523;
            14:      f = 587;
            15:      f = 659;
            default: f = 0;
        endcase
        return f;
    endfunction

    // Code 0 is a rest and yields a zero half period.
    function automatic int half_period(input int clk_hz, input int code);
        int f;
        f = note_hz(code);
        return (f == 0) ? 0 : clk_hz / (2 * f);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Duration tick generator: counts 0..TICK_DIV-1 while enabled.
// Emits a one-cycle tick on the last count; clr restarts at zero.
module tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic hush,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge hush) begin
        if (!hush) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + W'(1);
        end
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/tone_seq.sv
// One-note-per-request speaker tone sequencer with gap and handshake.
// Define TONE_DUTY_EN to add the duty[1:0] waveform shape input.
module tone_seq
    import sonido_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int CNT_W     = 18,
    parameter int DUR_W     = 8,
    parameter int GAP_TICKS = 1
) (
    input  logic             clk,
    input  logic             hush,
    input  logic             start,
    input  logic [3:0]       note,
    input  logic [DUR_W-1:0] dur,
`ifdef TONE_DUTY_EN
    input  logic [1:0]       duty,
`endif
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             ampPWM
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = CNT_W + 1;
    localparam logic [DUR_W-1:0] GAP_LAST =
        (GAP_TICKS > 0) ? DUR_W'(GAP_TICKS - 1) : '0;

    state_t           r_state;
    state_t           w_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_accept;
    logic             w_tick;
    logic [DUR_W-1:0] r_ticks;
    logic [DUR_W-1:0] r_dur;
    logic [PW-1:0]    r_ph;
    logic [PW-1:0]    r_p;
    logic [PW-1:0]    r_h;
    logic [PW-1:0]    w_ph_nxt;
    logic [PW-1:0]    w_p_in;
    logic [PW-1:0]    w_h_in;
    logic [CNT_W-1:0] w_hp_tab [16];

    for (genvar g = 0; g < 16; g++) begin : g_hp
        localparam int HP = half_period(CLK_HZ, g);
        assign w_hp_tab[g] = CNT_W'(HP);
    end

    assign w_p_in = {w_hp_tab[note], 1'b0};

`ifdef TONE_DUTY_EN
    logic [PW+1:0] w_p3;
    assign w_p3 = {2'b00, w_p_in} + {1'b0, w_p_in, 1'b0};

    always_comb begin
        w_h_in = w_p_in >> 1;
        unique case (duty)
            DUTY_25: w_h_in = w_p_in >> 2;
            DUTY_12: w_h_in = w_p_in >> 3;
            DUTY_75: w_h_in = PW'(w_p3 >> 2);
            default: w_h_in = w_p_in >> 1;
        endcase
    end
`else
    assign w_h_in = w_p_in >> 1;
`endif

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .hush (hush),
        .clr  (w_accept),
        .en   (busy),
        .tick (w_tick)
    );

    always_ff @(posedge clk or negedge hush) begin
        if (!hush) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_nxt      = r_state;
        w_done_nxt = 1'b0;
        w_accept   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_accept = 1'b1;
                    if (dur != '0) begin
                        w_nxt = PLAY;
                    end else if (GAP_TICKS != 0) begin
                        w_nxt = GAP;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (abort) begin
                    w_nxt = IDLE;
                end else if (w_tick && r_ticks == r_dur - DUR_W'(1)) begin
                    if (GAP_TICKS != 0) begin
                        w_nxt = GAP;
                    end else begin
                        w_nxt      = IDLE;
                        w_done_nxt = 1'b1;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    w_nxt = IDLE;
                end else if (w_tick && r_ticks == GAP_LAST) begin
                    w_nxt      = IDLE;
                    w_done_nxt = 1'b1;
                end
            end
            default: w_nxt = IDLE;
        endcase
    end

    assign w_ph_nxt = (r_ph == r_p - PW'(1)) ? '0 : r_ph + PW'(1);

    // A rest latches H=0, so the compare alone keeps the pin low.
    always_ff @(posedge clk or negedge hush) begin
        if (!hush) begin
            r_ticks <= '0;
            r_dur   <= '0;
            r_ph    <= '0;
            r_p     <= '0;
            r_h     <= '0;
            ampPWM  <= 1'b0;
        end else if (w_accept) begin
            r_ticks <= '0;
            r_dur   <= dur;
            r_ph    <= '0;
            r_p     <= w_p_in;
            r_h     <= w_h_in;
            ampPWM  <= (w_h_in != '0) && (dur != '0);
        end else if (r_state == PLAY && w_nxt == PLAY) begin
            r_ph    <= w_ph_nxt;
            ampPWM  <= w_ph_nxt < r_h;
            if (w_tick) r_ticks <= r_ticks + DUR_W'(1);
        end else if (r_state == GAP && w_nxt == GAP) begin
            ampPWM  <= 1'b0;
            if (w_tick) r_ticks <= r_ticks + DUR_W'(1);
        end else begin
            ampPWM  <= 1'b0;
            r_ticks <= '0;
        end
    end

    assign ready = (r_state == IDLE);
    assign busy  = (r_state == PLAY) || (r_state == GAP);
    assign done  = r_done;

endmodule

// File: tb/tb_tone_seq.sv
// Self-checking bench for tone_seq against a cycle-indexed note model.
// Define TONE_DUTY_EN to also exercise the duty shapes.
module tb_tone_seq;

    localparam int CLK = 1_000_000;
    localparam int THZ = 1000;
    localparam int TD  = CLK / THZ;
    localparam int GAP = 1;

    logic       clk   = 1'b0;
    logic       hush  = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] note  = '0;
    logic [7:0] dur   = '0;
`ifdef TONE_DUTY_EN
    logic [1:0] duty  = '0;
`endif
    logic       ready;
    logic       busy;
    logic       done;
    logic       ampPWM;

    int n_chk = 0;
    int n_err = 0;

    int FREQ [16] = '{0, 262, 277, 294, 311, 330, 349, 370,
                      392, 415, 440, 466, 494, 523, 587, 659};

    always #5 clk = ~clk;

    tone_seq #(
        .CLK_HZ    (CLK),
        .TICK_HZ   (THZ),
        .CNT_W     (18),
        .DUR_W     (8),
        .GAP_TICKS (GAP)
    ) dut (
        .clk    (clk),
        .hush   (hush),
        .start  (start),
        .note   (note),
        .dur    (dur),
`ifdef TONE_DUTY_EN
        .duty   (duty),
`endif
        .abort  (abort),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .ampPWM (ampPWM)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Expected {ready,busy,done,ampPWM} in cycle k after acceptance.
    function automatic logic [3:0] exp_out(input int k, input int nt,
                                           input int d, input int dy,
                                           input int ab);
        int   total;
        int   p;
        int   h;
        logic a;
        if (ab >= 0 && k > ab) return 4'b1000;
        total = (d + GAP) * TD;
        p = (nt == 0) ? 0 : 2 * (CLK / (2 * FREQ[nt]));
        case (dy)
            1:       h = p / 4;
            2:       h = p / 8;
            3:       h = (3 * p) / 4;
            default: h = p / 2;
        endcase
        a = 1'b0;
        if (p != 0 && k < d * TD) a = (k % p) < h;
        return {k >= total, k < total, k == total, a};
    endfunction

    // Entered and left at a negedge with the DUT idle.
    task automatic play(input int nt, input int d, input int dy,
                        input int ab, input int gl, input string nm);
        chk({nm, "_rdy"}, {31'b0, ready}, 32'd1);
        note  = 4'(nt);
        dur   = 8'(d);
        start = 1'b1;
`ifdef TONE_DUTY_EN
        duty  = 2'(dy);
`endif
        for (int k = 0; k <= (d + GAP) * TD + 1; k++) begin
            @(negedge clk);
            chk($sformatf("%s_k%0d", nm, k),
                {28'b0, ready, busy, done, ampPWM},
                {28'b0, exp_out(k, nt, d, dy, ab)});
            start = (k == gl);
            abort = (k == ab);
            note  = 4'($urandom);
            dur   = 8'($urandom);
`ifdef TONE_DUTY_EN
            duty  = 2'($urandom);
`endif
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int nt;
        int d;
        int dy;
        int ab;
        int gl;

        repeat (3) @(negedge clk);
        chk("reset", {28'b0, ready, busy, done, ampPWM}, 32'b1000);
        hush = 1'b1;
        @(negedge clk);

        play(10, 3, 0, -1, -1, "a4");
        play(0, 2, 0, -1, -1, "rest");
        play(5, 0, 0, -1, -1, "dur0");
        play(10, 3, 0, 500, -1, "abort");
        play(7, 2, 0, -1, 700, "ign_start");

        start = 1'b1;
        abort = 1'b1;
        note  = 4'd10;
        dur   = 8'd3;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("abort_start_%0d", k),
                {28'b0, ready, busy, done, ampPWM}, 32'b1000);
        end
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);

        note  = 4'd3;
        dur   = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("pre_hush_busy", {31'b0, busy}, 32'd1);
        #2 hush = 1'b0;
        #1 chk("async_hush", {28'b0, ready, busy, done, ampPWM}, 32'b1000);
        @(negedge clk);
        hush = 1'b1;
        @(negedge clk);
        play(12, 1, 0, -1, -1, "post_hush");

`ifdef TONE_DUTY_EN
        play(10, 1, 1, -1, -1, "duty25");
        play(10, 1, 3, -1, -1, "duty75");
        play(15, 1, 2, -1, -1, "duty12");
`endif

        for (int i = 0; i < 6; i++) begin
            nt = int'($urandom_range(0, 15));
            d  = int'($urandom_range(0, 3));
            dy = 0;
`ifdef TONE_DUTY_EN
            dy = int'($urandom_range(0, 3));
`endif
            ab = -1;
            gl = -1;
            if ($urandom_range(0, 2) == 0)
                ab = int'($urandom_range(0, (d + GAP) * TD - 2));
            else if ($urandom_range(0, 1) == 0)
                gl = int'($urandom_range(0, (d + GAP) * TD - 3));
            play(nt, d, dy, ab, gl, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
